// File: rtl/aead_pkg.sv
// aead_pkg: shared types for the keystream prefetcher.
// Algorithm codes, FSM encoding and a width helper.
package aead_pkg;

  localparam logic ALGO_AES = 1'b0;
  localparam logic ALGO_CC  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SPLIT,
    ST_DROP
  } ks_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/aead_ks_prefetch_if.sv
// aead_ks_prefetch_if: keystream beat stream.
// Producer drives valid/data, consumer drives ready.
interface aead_ks_prefetch_if #(
  parameter int W = 128
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/aead_ks_prefetch_fifo.sv
// ks_fifo: single-clock keystream FIFO.
// Wrap-bit pointers; flush clears pointers and beats push/pop.
module ks_fifo
  import aead_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign level  = wr_ptr - rd_ptr;
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr[AW-1:0]];

  // pointer update, flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aead_ks_prefetch.sv
// aead_ks_prefetch: keystream prefetch and dispatch.
// Requests AES/ChaCha blocks, splits them into beats, buffers them.
module aead_ks_prefetch
  import aead_pkg::*;
#(
  parameter int OUT_W = 128,
  parameter int AES_W = 128,
  parameter int CC_W  = 512,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic                   algo_sel,
  input  logic                   en,
  input  logic                   flush,
  output logic                   aes_ks_req,
  input  logic                   aes_ks_valid,
  input  logic [AES_W-1:0]       aes_ks_data,
  output logic                   cc_ks_req,
  input  logic                   cc_ks_valid,
  input  logic [CC_W-1:0]        cc_ks_data,
  aead_ks_prefetch_if.master     ks_out,
  output logic [clog2(DEPTH):0]  level,
  output logic                   algo,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       blk_cnt
);

  localparam int LW    = clog2(DEPTH) + 1;
  localparam int AES_N = AES_W / OUT_W;
  localparam int CC_N  = CC_W / OUT_W;

  ks_state_t        state;
  ks_state_t        state_nxt;
  logic [CC_W-1:0]  split;
  logic [LW-1:0]    beat;
  logic [LW-1:0]    n_beats;
  logic [LW-1:0]    free;
  logic             sel_valid;
  logic             cfg_ok;
  logic             take;
  logic             push;
  logic             fifo_empty;
  logic [OUT_W-1:0] head;

  assign n_beats   = (algo == ALGO_CC) ? LW'(CC_N) : LW'(AES_N);
  assign free      = LW'(DEPTH) - level;
  assign sel_valid = (algo == ALGO_CC) ? cc_ks_valid : aes_ks_valid;
  assign cfg_ok    = cfg_we && (state == ST_IDLE)
                  && (level == '0) && !flush;
  assign take      = (state == ST_WAIT) && sel_valid && !flush;
  assign push      = (state == ST_SPLIT) && !flush;

  assign aes_ks_req   = (state == ST_REQ) && (algo == ALGO_AES);
  assign cc_ks_req    = (state == ST_REQ) && (algo == ALGO_CC);
  assign busy         = (state != ST_IDLE);
  assign ks_out.valid = !fifo_empty;
  assign ks_out.data  = fifo_empty ? '0 : head;

  // next state; a response coinciding with flush in WAIT is simply dropped
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (en && !flush && !cfg_ok && (free >= n_beats))
          state_nxt = ST_REQ;
      ST_REQ:
        state_nxt = flush ? ST_DROP : ST_WAIT;
      ST_WAIT:
        if (flush)
          state_nxt = sel_valid ? ST_IDLE : ST_DROP;
        else if (sel_valid)
          state_nxt = ST_SPLIT;
      ST_SPLIT:
        if (flush || (beat == n_beats - LW'(1)))
          state_nxt = ST_IDLE;
      ST_DROP:
        if (sel_valid)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // state register, algorithm select and config error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      algo    <= ALGO_AES;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok)
        algo <= algo_sel;
    end
  end

  // block capture, beat shifting and block counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split   <= '0;
      beat    <= '0;
      blk_cnt <= '0;
    end else begin
      if (take) begin
        split <= (algo == ALGO_CC) ? cc_ks_data : CC_W'(aes_ks_data);
        beat  <= '0;
      end else if (push) begin
        split <= split >> OUT_W;
        beat  <= beat + LW'(1);
      end
      if (flush)
        blk_cnt <= '0;
      else if (take)
        blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

  ks_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (ks_out.ready),
    .flush (flush),
    .wdata (split[OUT_W-1:0]),
    .rdata (head),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_aead_ks_prefetch.sv
// tb_aead_ks_prefetch: table vectors, corner sequences, random traffic.
// Engines and consumer are modelled as queues of expected beats.
module tb_aead_ks_prefetch;
  import aead_pkg::*;

  localparam int OUT_W = 128;
  localparam int AES_W = 128;
  localparam int CC_W  = 512;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we = 1'b0;
  logic             algo_sel = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             aes_ks_req;
  logic             aes_ks_valid = 1'b0;
  logic [AES_W-1:0] aes_ks_data = '0;
  logic             cc_ks_req;
  logic             cc_ks_valid = 1'b0;
  logic [CC_W-1:0]  cc_ks_data = '0;
  logic [LW-1:0]    level;
  logic             algo;
  logic             busy;
  logic             cfg_err;
  logic [CNT_W-1:0] blk_cnt;

  aead_ks_prefetch_if #(.W(OUT_W)) ks_if ();

  aead_ks_prefetch #(
    .OUT_W (OUT_W),
    .AES_W (AES_W),
    .CC_W  (CC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .algo_sel     (algo_sel),
    .en           (en),
    .flush        (flush),
    .aes_ks_req   (aes_ks_req),
    .aes_ks_valid (aes_ks_valid),
    .aes_ks_data  (aes_ks_data),
    .cc_ks_req    (cc_ks_req),
    .cc_ks_valid  (cc_ks_valid),
    .cc_ks_data   (cc_ks_data),
    .ks_out       (ks_if),
    .level        (level),
    .algo         (algo),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .blk_cnt      (blk_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit sb_on = 1'b1;
  bit eng_rand = 1'b0;
  bit en_rand = 1'b0;
  bit flush_req = 1'b0;
  int dly_min = 3;
  int dly_max = 3;
  int rdy_pct = 0;
  int flush_pct = 0;
  int pops_left = 0;
  int n_pops = 0;

  bit pend = 1'b0;
  bit drop = 1'b0;
  int cnt = 0;
  int req_cnt = 0;
  bit last_aes = 1'b0;
  bit last_cc = 1'b0;
  bit model_algo = 1'b0;
  int model_blk = 0;
  logic [OUT_W-1:0] exp_q [$];
  logic [AES_W-1:0] fix_aes = '0;
  logic [CC_W-1:0]  fix_cc = '0;

  typedef struct {
    bit algo;
    bit en;
    int cycles;
    int exp_level;
    int exp_blk;
    int exp_req;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [CC_W-1:0] rand_blk();
    logic [CC_W-1:0] b;
    for (int j = 0; j < CC_W / 32; j++) b[j*32 +: 32] = $urandom;
    return b;
  endfunction

  // engine answers: drive the strobe and queue the expected beats
  task automatic respond();
    logic [CC_W-1:0] b;
    int n;
    b = eng_rand ? rand_blk() : fix_cc;
    if (model_algo == ALGO_CC) begin
      cc_ks_data = b;
      cc_ks_valid = 1'b1;
      n = CC_W / OUT_W;
    end else begin
      b = eng_rand ? CC_W'(b[AES_W-1:0]) : CC_W'(fix_aes);
      aes_ks_data = b[AES_W-1:0];
      aes_ks_valid = 1'b1;
      n = AES_W / OUT_W;
    end
    if (!drop) begin
      model_blk++;
      for (int i = 0; i < n; i++) exp_q.push_back(b[i*OUT_W +: OUT_W]);
    end
  endtask

  // one clock: check, then drive the next cycle's inputs
  task automatic cyc();
    @(negedge clk);
    if (sb_on) begin
      chk("blk_cnt", blk_cnt, model_blk);
      chk("level_le_depth", level > DEPTH, 0);
      chk("valid_vs_level", ks_if.valid, level != 0);
    end
    flush = flush_req || (flush_pct > 0 && $urandom_range(99) < flush_pct);
    flush_req = 1'b0;
    if (en_rand) en = ($urandom_range(99) < 85);
    aes_ks_valid = 1'b0;
    cc_ks_valid = 1'b0;
    if (aes_ks_req || cc_ks_req) begin
      req_cnt++;
      last_aes = aes_ks_req;
      last_cc = cc_ks_req;
      chk("one_outstanding", pend, 0);
      chk("req_engine", cc_ks_req, model_algo);
      chk("req_onehot", aes_ks_req && cc_ks_req, 0);
      pend = 1'b1;
      drop = 1'b0;
      cnt = $urandom_range(dly_max, dly_min);
    end else if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        pend = 1'b0;
        respond();
      end
    end
    ks_if.ready = (pops_left > 0) || ($urandom_range(99) < rdy_pct);
    if (ks_if.valid && ks_if.ready) begin
      n_pops++;
      if (pops_left > 0) pops_left--;
      if (sb_on) begin
        chk("beat_expected", exp_q.size() == 0, 0);
        if (exp_q.size() != 0)
          chk("ks_out_data", ks_if.data, exp_q.pop_front());
      end
    end
    if (flush) begin
      exp_q.delete();
      model_blk = 0;
      if (pend) drop = 1'b1;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {aes_ks_req, cc_ks_req, ks_if.valid, level, algo,
                        busy, cfg_err, blk_cnt, |ks_if.data}, '0);
    pend = 1'b0; drop = 1'b0; exp_q.delete();
    model_blk = 0; model_algo = 1'b0; req_cnt = 0;
    flush = 1'b0; flush_req = 1'b0; flush_pct = 0;
    cfg_we = 1'b0; en = 1'b0; en_rand = 1'b0; pops_left = 0;
    aes_ks_valid = 1'b0; cc_ks_valid = 1'b0; ks_if.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic set_algo(input bit a);
    cfg_we = 1'b1;
    algo_sel = a;
    cyc();
    cfg_we = 1'b0;
    model_algo = a;
    chk("cfg_algo", algo, a);
    chk("cfg_err_clear", cfg_err, 0);
  endtask

  task automatic drain();
    en = 1'b0; en_rand = 1'b0; flush_pct = 0; rdy_pct = 100;
    for (int k = 0; k < 300 && (pend || busy || level != 0); k++) cyc();
    chk("drain_done", pend || busy || level != 0, 0);
    chk("drain_queue", exp_q.size(), 0);
    rdy_pct = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ks_if.ready = 1'b0;
    tbl[0] = '{1'b0, 1'b1, 100, 8, 8, 8};
    tbl[1] = '{1'b1, 1'b1, 100, 8, 2, 2};
    tbl[2] = '{1'b0, 1'b0, 40, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 40, 0, 0, 0};

    // table: fill with no consumer until saturation
    for (int v = 0; v < 4; v++) begin
      do_reset();
      eng_rand = 1'b1; dly_min = 3; dly_max = 3; rdy_pct = 0;
      set_algo(tbl[v].algo);
      req_cnt = 0;
      en = tbl[v].en;
      repeat (tbl[v].cycles) cyc();
      chk("tbl_level", level, tbl[v].exp_level);
      chk("tbl_blk", blk_cnt, tbl[v].exp_blk);
      chk("tbl_reqs", req_cnt, tbl[v].exp_req);
      chk("tbl_queue", exp_q.size(), tbl[v].exp_level);
      drain();
    end

    // AES fixed block: 2-cycle latency, then streaming
    do_reset();
    eng_rand = 1'b0; fix_aes = 128'h00112233445566778899AABBCCDDEEFF;
    dly_min = 3; dly_max = 3; rdy_pct = 0; en = 1'b1;
    for (int k = 0; k < 20 && !aes_ks_valid; k++) cyc();
    chk("a_resp_seen", aes_ks_valid, 1);
    en = 1'b0;
    cyc();
    chk("a_lat_1", ks_if.valid, 0);
    cyc();
    chk("a_lat_2", ks_if.valid, 1);
    chk("a_lat_data", ks_if.data, fix_aes);
    rdy_pct = 100; en = 1'b1; req_cnt = 0;
    repeat (60) cyc();
    chk("a_reqs", req_cnt >= 5, 1);
    drain();

    // ChaCha fixed block: beat order and full-FIFO throttling
    do_reset();
    set_algo(1'b1);
    eng_rand = 1'b0;
    fix_cc = {128'd3, 128'd2, 128'd1, 128'd0};
    rdy_pct = 0; en = 1'b1;
    for (int k = 0; k < 60 && level != 8; k++) cyc();
    chk("b_level_full", level, 8);
    chk("b_head", ks_if.data, 0);
    repeat (20) cyc();
    chk("b_reqs_full", req_cnt, 2);
    pops_left = 3;
    for (int k = 0; k < 20 && pops_left > 0; k++) cyc();
    repeat (20) cyc();
    chk("b_level_5", level, 5);
    chk("b_reqs_5", req_cnt, 2);
    pops_left = 1;
    for (int k = 0; k < 20 && req_cnt < 3; k++) cyc();
    chk("b_req_after_pop", req_cnt, 3);
    drain();

    // cfg rejected while data buffered, accepted when drained
    do_reset();
    eng_rand = 1'b1; dly_min = 2; dly_max = 2; rdy_pct = 0; en = 1'b1;
    for (int k = 0; k < 100 && level < 3; k++) cyc();
    en = 1'b0;
    for (int k = 0; k < 50 && busy; k++) cyc();
    pops_left = int'(level) - 3;
    for (int k = 0; k < 20 && pops_left > 0; k++) cyc();
    cyc();
    chk("c_level3", level, 3);
    cfg_we = 1'b1; algo_sel = 1'b1;
    cyc();
    cfg_we = 1'b0;
    chk("c_cfg_err", cfg_err, 1);
    chk("c_algo_kept", algo, 0);
    cyc();
    chk("c_err_pulse", cfg_err, 0);
    drain();
    set_algo(1'b1);
    req_cnt = 0; en = 1'b1;
    for (int k = 0; k < 20 && req_cnt == 0; k++) cyc();
    chk("c_cc_req", last_cc, 1);
    drain();
    flush_req = 1'b1;
    cyc();
    cfg_we = 1'b1; algo_sel = 1'b0;
    cyc();
    cfg_we = 1'b0;
    chk("c_flush_cfg_err", cfg_err, 1);
    chk("c_flush_algo", algo, 1);

    // flush during WAIT, late response discarded in DROP
    do_reset();
    eng_rand = 1'b1; dly_min = 7; dly_max = 7; rdy_pct = 0; en = 1'b1;
    for (int k = 0; k < 40 && req_cnt < 2; k++) cyc();
    chk("d_blk_pre", blk_cnt, 1);
    chk("d_level_pre", level, 1);
    flush_req = 1'b1;
    cyc();
    cyc();
    chk("d_level_flush", level, 0);
    chk("d_blk_flush", blk_cnt, 0);
    chk("d_busy_drop", busy, 1);
    flush_req = 1'b1;
    cyc();
    cyc();
    chk("d_drop_kept", busy, 1);
    chk("d_no_req", req_cnt, 2);
    for (int k = 0; k < 20 && pend; k++) cyc();
    cyc();
    chk("d_blk_discard", blk_cnt, 0);
    chk("d_level_discard", level, 0);
    for (int k = 0; k < 20 && req_cnt < 3; k++) cyc();
    chk("d_fresh_req", req_cnt, 3);
    drain();

    // spurious strobes: wrong engine, and right engine while IDLE
    do_reset();
    set_algo(1'b1);
    eng_rand = 1'b1; dly_min = 6; dly_max = 6; rdy_pct = 0;
    aes_ks_valid = 1'b1; aes_ks_data = 128'hDEAD;
    cyc();
    cc_ks_valid = 1'b1;
    cyc();
    cyc();
    chk("e_idle_level", level, 0);
    chk("e_idle_blk", blk_cnt, 0);
    en = 1'b1;
    for (int k = 0; k < 20 && req_cnt == 0; k++) cyc();
    cyc();
    aes_ks_valid = 1'b1;
    cyc();
    cyc();
    chk("e_wait_blk", blk_cnt, 0);
    chk("e_wait_level", level, 0);
    en = 1'b0;
    for (int k = 0; k < 20 && pend; k++) cyc();
    cyc();
    chk("e_real_blk", blk_cnt, 1);
    drain();

    // asynchronous reset in the middle of a ChaCha split
    do_reset();
    set_algo(1'b1);
    eng_rand = 1'b1; dly_min = 2; dly_max = 2; rdy_pct = 0; en = 1'b1;
    for (int k = 0; k < 60 && level != 5; k++) cyc();
    chk("f_level5", level, 5);
    chk("f_busy", busy, 1);
    do_reset();
    chk("f_algo", algo, 0);
    chk("f_idle", busy, 0);
    en = 1'b1;
    for (int k = 0; k < 20 && req_cnt == 0; k++) cyc();
    chk("f_aes_req", last_aes, 1);
    drain();

    // random traffic on both algorithms
    for (int a = 0; a < 2; a++) begin
      do_reset();
      set_algo(a[0]);
      eng_rand = 1'b1; dly_min = 1; dly_max = 6;
      rdy_pct = 50; flush_pct = 3; en_rand = 1'b1; n_pops = 0;
      repeat (1500) cyc();
      chk("r_activity", n_pops > 20, 1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aead_ks_prefetch.md
Name: aead_ks_prefetch

Overview:
- Parametrised keystream prefetcher and dispatcher that sits between the AES-GCM datapath, the ChaCha20 core and the payload XOR stage.
- Owns request generation to the selected engine and buffers keystream in a DEPTH-word FIFO.
- Splits wide engine blocks (128b AES, 512b ChaCha) into uniform OUT_W beats behind a valid/ready interface.
- Replaces the fixed zero-extending keystream mux with width-normalised, back-pressured delivery and safe algorithm switching.

Parameters:
- OUT_W, 128, output beat width; must divide AES_W and CC_W.
- AES_W, 128, AES keystream block width.
- CC_W, 512, ChaCha keystream block width.
- DEPTH, 8, FIFO depth in OUT_W words; must be >= CC_W/OUT_W and a power of 2.
- CNT_W, 32, width of the block counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  algorithm-select write strobe.
- algo_sel  in  1  0 = AES, 1 = ChaCha; sampled on an accepted cfg_we.
- en  in  1  prefetch enable (level).
- flush  in  1  discard buffered and in-flight keystream.
- aes_ks_req  out  1  one-cycle request to the AES engine.
- aes_ks_valid  in  1  AES response strobe.
- aes_ks_data  in  AES_W  AES keystream block.
- cc_ks_req  out  1  one-cycle request to the ChaCha engine.
- cc_ks_valid  in  1  ChaCha response strobe.
- cc_ks_data  in  CC_W  ChaCha keystream block.
- ks_out_valid  out  1  FIFO non-empty.
- ks_out_ready  in  1  consumer accept.
- ks_out_data  out  OUT_W  head word.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- algo  out  1  active algorithm.
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse when a cfg_we is rejected.
- blk_cnt  out  CNT_W  engine blocks accepted since reset or flush; wraps.

Behaviour:
- Reset: all outputs 0, algo = 0, FIFO empty, state IDLE. Reset may assert at any time; it aborts all activity and the engine's late response is ignored.
- N = AES_W/OUT_W when algo = 0, else CC_W/OUT_W. free = DEPTH - level.
- IDLE -> REQ when en && !flush && free >= N.
- REQ: pulse the selected engine's req for exactly one cycle, then go to WAIT.
- WAIT: on the selected engine's ks_valid, capture the block into the split register, increment blk_cnt, go to SPLIT.
  - The non-selected engine's valid is ignored in every state.
  - A selected-engine valid seen in IDLE, REQ or SPLIT is ignored.
- SPLIT: push split[OUT_W-1:0] each cycle, then shift right by OUT_W. After N pushes go to IDLE.
  - The first beat goes out on the first SPLIT cycle, so latency from ks_valid to ks_out_valid is 2 cycles when the FIFO was empty.
  - The free >= N check guarantees pushes never overflow. The FIFO does not stall SPLIT.
- At most one request is outstanding at any time.
- Output side:
  - Pop occurs on ks_out_valid && ks_out_ready.
  - Push and pop in the same cycle leave level unchanged.
  - ks_out_data is stable while valid && !ready.
  - Ready while empty has no effect.
- Flush (highest priority):
  - FIFO pointers reset, level = 0, blk_cnt = 0 next cycle.
  - SPLIT -> IDLE with the remaining beats dropped.
  - REQ or WAIT -> DROP. DROP waits for the selected engine's valid, discards it without counting, then goes to IDLE.
  - Flush while in DROP keeps DROP.
- cfg_we:
  - Accepted only when state is IDLE, level == 0 and no flush in the same cycle; then algo <= algo_sel.
  - Otherwise algo is unchanged and cfg_err pulses the next cycle.
  - An accepted cfg_we blocks the IDLE->REQ transition in that cycle.
- Counters and pointers wrap modulo their width; FIFO pointers are clog2(DEPTH) bits plus a wrap bit.

Decomposition:
- Shared package aead_pkg: ALGO_AES = 1'b0, ALGO_CC = 1'b1, the state encoding (IDLE, REQ, WAIT, SPLIT, DROP), and a clog2 function.
- One natural sub-module, ks_fifo: synchronous single-clock FIFO, parametrised by width and depth, with push, pop, flush, level, and registered-pointer read data.

Test Plan:
- AES, OUT_W = 128, DEPTH = 8, en = 1; engine answers 3 cycles after req with 0x00112233445566778899AABBCCDDEEFF; ready = 1 -> one aes_ks_req pulse per block, ks_out_data equals the block, blk_cnt increments by 1, the FIFO is never over DEPTH.
- ChaCha block with word i = 0x0..0i for i = 0..3; ready held 0 -> four beats emitted in order 0,1,2,3. After 2 blocks level = 8 and no further cc_ks_req until a pop frees 4 words.
- cfg_we with algo_sel = 1 while level = 3 -> cfg_err pulses and algo stays 0. After draining to level 0 in IDLE, the same cfg_we gives algo = 1 and the next request is cc_ks_req.
- Flush during WAIT, response arriving 5 cycles later -> state DROP; the response is discarded, level = 0, blk_cnt = 0, and a fresh request is issued afterwards.
- Spurious aes_ks_valid while algo = 1, plus a valid asserted in IDLE -> no push, blk_cnt unchanged.
- rst_n asserted mid-SPLIT with level = 5 -> all outputs 0 immediately (asynchronous); after release the block restarts from IDLE with algo = 0.
